tuner_input_sched: RTL
======================

# tuner_input_sched

Input scheduler in front of the tuner: turns raw step buttons, a one-hot key matrix and an optional auto-scan into single-cycle, mutually exclusive tuner commands. It sits between the debounced front panel and the tuner's high/low/freq_in/h_in inputs. It guarantees at most one command per dclk cycle, and it never asserts a step and a direct note together. It adds hold-to-repeat on the step buttons.

## Interface
- HOLD_CYC, 50: dclk cycles a step button is held before the first auto-repeat pulse.
- REPEAT_CYC, 10: dclk cycles between subsequent repeat pulses.
- SCAN_CYC, 25: dclk cycles between auto-scan step pulses.
- CNT_W, 16: timer width; must hold max(HOLD_CYC, REPEAT_CYC, SCAN_CYC).
- dclk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up, btn_dn  in  1 each  debounced, dclk-synchronous step-button levels.
- key_vld  in  1  key matrix strobe, one cycle.
- key_note  in  13  one-hot note, C..B plus X at bit 12.
- key_oct  in  5  one-hot octave.
- scan_go  in  1  pulse; toggles auto-scan.
- tn_high, tn_low  out  1 each  step pulses to the tuner.
- tn_freq  out  13  one-hot note to the tuner; all-zero when idle.
- tn_h  out  5  one-hot octave to the tuner; all-zero when idle.
- scan_on  out  1  auto-scan active.
- busy  out  1  a step button hold is in progress (state not IDLE).

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE and the timer to 0.
- The button-previous registers reset to 1, so a button held through reset produces no pulse until it is released and pressed again.
- Priority per cycle: key > button > scan. At most one of tn_high, tn_low or a nonzero tn_freq/tn_h is asserted in any cycle.
- Key path:
  - Accepted when key_vld=1, key_note is exactly one-hot and key_oct is exactly one-hot.
  - On acceptance, tn_freq=key_note and tn_h=key_oct for one cycle.
  - Non-one-hot input is dropped silently.
- Step FSM states: IDLE, HOLD, RPT, BLOCK.
  - IDLE, rising edge on exactly one button: pulse tn_high (up) or tn_low (dn), load timer with HOLD_CYC-1, go to HOLD.
  - HOLD/RPT, same button still high: decrement the timer. At 0, pulse again, reload with REPEAT_CYC-1, go to RPT.
  - HOLD/RPT, button released: go to IDLE.
  - Any state, both buttons high: go to BLOCK with no pulses. BLOCK exits to IDLE only when both buttons are low.
  - Both buttons rising in the same cycle: go to BLOCK, no pulse.
- Conflicts:
  - A key accepted in a cycle where a step pulse is due wins. The step pulse is dropped and the timer reloads REPEAT_CYC-1 as if it had fired.
  - A key or any button press clears scan_on.

## Timing
- Latency is 1 dclk from an input edge or strobe to the output pulse. Each pulse is exactly 1 cycle wide.
- First repeat fires HOLD_CYC cycles after the initial pulse. Later repeats are spaced REPEAT_CYC cycles apart.
- Scan pulses tn_high every SCAN_CYC cycles. The first pulse comes SCAN_CYC cycles after scan_on rises.
- The tuner's own wrap (B to C with octave carry) is left to the tuner; this block does not track the note.
- An asynchronous reset mid-hold returns the block to IDLE immediately and clears all outputs.

## Configuration
- TUNER_SCAN_EN defined: scan_go toggles scan_on. Scan pulses are issued only while the FSM is in IDLE and no key is accepted. A key or button press stops scan.
- TUNER_SCAN_EN undefined: scan_on is tied to 0, scan_go is ignored and the scan timer is not built.

## Structure
- tuner_pkg holds:
  - note encodings C=0 .. B=11, X=12;
  - NOTE_W=13 and OCT_W=5;
  - the FSM state enum;
  - an is_onehot function.
- Sub-module hold_repeat_timer contains the loadable down-counter with its zero flag. It is instantiated once for the step path and, under the macro, once for scan.

## Test plan
Benches use HOLD_CYC=4, REPEAT_CYC=2, SCAN_CYC=3.
1. Reset with btn_up held, then release rst_n → no pulse. Release btn_up, press it again → tn_high on the next cycle.
2. Hold btn_up for 12 cycles → tn_high at cycles 1, 5, 7, 9, 11; busy=1 throughout. Release → IDLE.
3. key_vld with key_note=0x200 and key_oct=0x04 → tn_freq=0x200 and tn_h=0x04 for 1 cycle. key_note=0x201 → no output.
4. Press btn_up, then btn_dn 2 cycles later → no further pulses in BLOCK. Release both, press btn_dn → one tn_low pulse.
5. Key strobe on the same cycle a repeat is due → only tn_freq/tn_h asserted. The next repeat follows 2 cycles later.
6. With TUNER_SCAN_EN: scan_go → tn_high every 3 cycles. A btn_dn press → one tn_low pulse, scan_on=0, and no further scan pulses.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared definitions for the tuner input scheduler: note/octave widths,
// note encodings, the step FSM state type and a one-hot test.
package tuner_pkg;

  localparam int NOTE_W = 13;
  localparam int OCT_W  = 5;

  // Note index within an octave; X is the extra key at bit 12.
  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11,
    NOTE_X  = 4'd12
  } note_e;

  // Step-button FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RPT   = 2'd2,
    ST_BLOCK = 2'd3
  } step_state_e;

  // True when exactly one bit is set; narrower vectors are zero-extended.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement; the counter parks at zero rather than wrapping.
module hold_repeat_timer #(
  parameter int CNT_W = 16
) (
  input  logic             dclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Count register: reload or step down towards zero.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tuner_input_sched.sv
// Tuner input scheduler: merges step buttons (with hold-to-repeat), the
// key matrix and optional auto-scan into single-cycle, mutually exclusive
// tuner commands. Priority per cycle is key > button > scan.
// Optional feature: define TUNER_SCAN_EN to build the auto-scan path.
module tuner_input_sched
  import tuner_pkg::*;
#(
  parameter int HOLD_CYC   = 50,
  parameter int REPEAT_CYC = 10,
  parameter int SCAN_CYC   = 25,
  parameter int CNT_W      = 16
) (
  input  logic              dclk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic              key_vld,
  input  logic [NOTE_W-1:0] key_note,
  input  logic [OCT_W-1:0]  key_oct,
  input  logic              scan_go,
  output logic              tn_high,
  output logic              tn_low,
  output logic [NOTE_W-1:0] tn_freq,
  output logic [OCT_W-1:0]  tn_h,
  output logic              scan_on,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(REPEAT_CYC - 1);

  step_state_e      state_reg, state_next;
  logic             up_sel_reg, up_sel_next;
  logic             up_prev_reg, dn_prev_reg;
  logic             rise_up, rise_dn, any_press;
  logic             key_acc;
  logic             step_fire, step_load, step_dec, step_zero;
  logic [CNT_W-1:0] step_load_val;
  logic             scan_fire, scan_on_next;
  logic             tn_high_next, tn_low_next, busy_next;
  logic [NOTE_W-1:0] tn_freq_next;
  logic [OCT_W-1:0]  tn_h_next;

  assign rise_up   = btn_up & ~up_prev_reg;
  assign rise_dn   = btn_dn & ~dn_prev_reg;
  assign any_press = rise_up | rise_dn;
  assign key_acc   = key_vld
                   & is_onehot({{(16-NOTE_W){1'b0}}, key_note})
                   & is_onehot({{(16-OCT_W){1'b0}}, key_oct});

  // Button history; starts high so a button held through reset is ignored.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      up_prev_reg <= 1'b1;
      dn_prev_reg <= 1'b1;
    end else begin
      up_prev_reg <= btn_up;
      dn_prev_reg <= btn_dn;
    end
  end

  // Step FSM state and held-button direction.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      up_sel_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      up_sel_reg <= up_sel_next;
    end
  end

  // Next-state logic; a due step still fires internally (timer reload,
  // state advance) even when a key masks the pulse this cycle.
  always_comb begin
    state_next    = state_reg;
    up_sel_next   = up_sel_reg;
    step_fire     = 1'b0;
    step_load     = 1'b0;
    step_load_val = HOLD_LD;
    step_dec      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (btn_up && btn_dn) begin
          state_next = ST_BLOCK;
        end else if (rise_up ^ rise_dn) begin
          state_next    = ST_HOLD;
          up_sel_next   = rise_up;
          step_fire     = 1'b1;
          step_load     = 1'b1;
          step_load_val = HOLD_LD;
        end
      end
      ST_HOLD, ST_RPT: begin
        if (btn_up && btn_dn) begin
          state_next = ST_BLOCK;
        end else if (up_sel_reg ? btn_up : btn_dn) begin
          if (step_zero) begin
            state_next    = ST_RPT;
            step_fire     = 1'b1;
            step_load     = 1'b1;
            step_load_val = RPT_LD;
          end else begin
            step_dec = 1'b1;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BLOCK: begin
        if (!btn_up && !btn_dn) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  hold_repeat_timer #(.CNT_W(CNT_W)) u_step_timer (
    .dclk     (dclk),
    .rst_n    (rst_n),
    .load     (step_load),
    .load_val (step_load_val),
    .dec      (step_dec),
    .zero     (step_zero)
  );

`ifdef TUNER_SCAN_EN
  logic scan_zero, scan_due, scan_load, scan_dec;

  assign scan_due  = scan_on & scan_zero;
  assign scan_fire = scan_due & scan_on_next & (state_reg == ST_IDLE) & ~key_acc;
  assign scan_load = (scan_on_next & ~scan_on) | scan_due;
  assign scan_dec  = scan_on & ~scan_zero;

  // Scan enable: user input stops scan, scan_go toggles it otherwise.
  always_comb begin
    scan_on_next = scan_on;
    if (key_acc || any_press) begin
      scan_on_next = 1'b0;
    end else if (scan_go) begin
      scan_on_next = ~scan_on;
    end
  end

  hold_repeat_timer #(.CNT_W(CNT_W)) u_scan_timer (
    .dclk     (dclk),
    .rst_n    (rst_n),
    .load     (scan_load),
    .load_val (CNT_W'(SCAN_CYC - 1)),
    .dec      (scan_dec),
    .zero     (scan_zero)
  );
`else
  logic unused_scan;

  assign unused_scan  = scan_go ^ (SCAN_CYC != 0);
  assign scan_fire    = 1'b0;
  assign scan_on_next = 1'b0;
`endif

  // Output decode: key masks step pulses; scan only fires when idle.
  always_comb begin
    tn_high_next = (step_fire & ~key_acc & up_sel_next) | scan_fire;
    tn_low_next  = step_fire & ~key_acc & ~up_sel_next;
    tn_freq_next = key_acc ? key_note : '0;
    tn_h_next    = key_acc ? key_oct : '0;
    busy_next    = (state_next != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      tn_high <= 1'b0;
      tn_low  <= 1'b0;
      tn_freq <= '0;
      tn_h    <= '0;
      scan_on <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tn_high <= tn_high_next;
      tn_low  <= tn_low_next;
      tn_freq <= tn_freq_next;
      tn_h    <= tn_h_next;
      scan_on <= scan_on_next;
      busy    <= busy_next;
    end
  end

endmodule
